// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one 32-bit memory bus between instruction fetch and load/store,
// with byte-lane steering, load extension, misalignment detection and bus timeout. Rev 1.0
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic        d_usign,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_WAIT = 2'd1,
    DATA_WAIT  = 2'd2,
    RESP       = 2'd3
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          usign_q;
  logic          bus_req_q, bus_we_q;
  logic [31:0]   bus_addr_q, bus_wdata_q;
  logic [3:0]    bus_be_q;
  logic          if_done_q, if_err_q, d_done_q, d_err_q;
  logic [31:0]   if_rdata_q, d_rdata_q;

  logic          d_req;
  logic          d_mis;
  logic [1:0]    size_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;
  logic          timed_out;

  // Decode of the pending data request; size 11 folds onto word.
  always_comb begin
    d_req   = d_read | d_write;
    size_d  = (d_size == 2'b11) ? 2'b10 : d_size;
    be_d    = 4'b1111;
    d_mis   = 1'b0;
    wdata_d = d_wdata;
    case (size_d)
      2'b00: begin
        be_d    = 4'b0001 << d_addr[1:0];
        wdata_d = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << d_addr[1:0];
        d_mis   = d_addr[0];
        wdata_d = {2{d_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        d_mis   = |d_addr[1:0];
        wdata_d = d_wdata;
      end
    endcase
  end

  always_comb begin
    shifted  = bus_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'b00:   load_ext = usign_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = usign_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // An ack in the final counted cycle takes precedence over the timeout.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !bus_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      usign_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (d_req) begin
            if (d_mis) begin
              d_done_q  <= 1'b1;
              d_err_q   <= 1'b1;
              d_rdata_q <= '0;
              state_q   <= RESP;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= d_write;
              bus_addr_q  <= {d_addr[31:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= d_write ? wdata_d : 32'd0;
              off_q       <= d_addr[1:0];
              size_q      <= size_d;
              usign_q     <= d_usign;
              state_q     <= DATA_WAIT;
            end
          end else if (if_req) begin
            if (|if_addr[1:0]) begin
              if_done_q  <= 1'b1;
              if_err_q   <= 1'b1;
              if_rdata_q <= '0;
              state_q    <= RESP;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= 1'b0;
              bus_addr_q  <= if_addr;
              bus_be_q    <= 4'b1111;
              bus_wdata_q <= '0;
              state_q     <= FETCH_WAIT;
            end
          end
        end
        FETCH_WAIT, DATA_WAIT: begin
          if (bus_ack || timed_out) begin
            bus_req_q <= 1'b0;
            state_q   <= RESP;
            if (state_q == FETCH_WAIT) begin
              if_done_q  <= 1'b1;
              if_err_q   <= !bus_ack;
              if_rdata_q <= bus_ack ? bus_rdata : 32'd0;
            end else begin
              d_done_q  <= 1'b1;
              d_err_q   <= !bus_ack;
              d_rdata_q <= (bus_ack && !bus_we_q) ? load_ext : 32'd0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if_done_q <= 1'b0;
          if_err_q  <= 1'b0;
          d_done_q  <= 1'b0;
          d_err_q   <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: randomized requester/slave stimulus with a queue-based scoreboard
// against a behavioural model of the memory port arbiter. Rev 1.0
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done, if_err;
  logic        d_read, d_write;
  logic [1:0]  d_size;
  logic        d_usign;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_done, d_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } plan_t;

  resp_t exp_q[$];
  plan_t plan_q[$];
  int    vectors = 0;
  int    errors  = 0;
  bit    slave_en = 1'b1;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .d_read(d_read), .d_write(d_write), .d_size(d_size), .d_usign(d_usign),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_ctl"}, {22'd0, bus_req, bus_we, bus_be, if_done, if_err, d_done, d_err}, 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // Requester: issues one fetch and/or one data access, models the expected outcome,
  // then holds each request until its done pulse.
  task automatic run_txn(input bit do_f, input bit do_d, input bit wr, input logic [1:0] sz,
                         input bit us, input logic [31:0] daddr, input logic [31:0] wdata,
                         input logic [31:0] faddr, input int fdelay, input int ddelay,
                         input logic [31:0] frdata, input logic [31:0] drdata, input int gap);
    int          s;
    logic [1:0]  off;
    bit          mis;
    logic [31:0] v;
    int          exp_lat;
    int          k;
    bit          pend_f, pend_d;
    resp_t       r;
    plan_t       p;
    exp_lat = 0;
    repeat (gap) @(negedge clk);
    if (do_d) begin
      s   = (sz == 2'd3) ? 2 : int'(sz);
      off = daddr[1:0];
      mis = (s == 1 && off[0]) || (s == 2 && off != 2'd0);
      if (mis) begin
        r = '{is_d: 1'b1, rdata: 32'd0, err: 1'b1};
        exp_lat = 1;
      end else begin
        p.we    = wr;
        p.addr  = daddr & 32'hFFFF_FFFC;
        p.be    = (s == 0) ? 4'(1 << off) : (s == 1) ? 4'(3 << off) : 4'hF;
        p.wdata = (s == 0) ? (wdata & 32'hFF) * 32'h0101_0101 :
                  (s == 1) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
        p.delay = ddelay;
        p.rdata = drdata;
        plan_q.push_back(p);
        v = drdata >> (8 * off);
        if (s == 0) begin
          v = v & 32'hFF;
          if (!us && v[7]) v = v | 32'hFFFF_FF00;
        end else if (s == 1) begin
          v = v & 32'hFFFF;
          if (!us && v[15]) v = v | 32'hFFFF_0000;
        end
        if (ddelay >= TO) r = '{is_d: 1'b1, rdata: 32'd0, err: 1'b1};
        else              r = '{is_d: 1'b1, rdata: (wr ? 32'd0 : v), err: 1'b0};
        exp_lat = (ddelay >= TO) ? TO + 1 : ddelay + 2;
      end
      exp_q.push_back(r);
    end
    if (do_f) begin
      if (faddr[1:0] != 2'd0) begin
        r = '{is_d: 1'b0, rdata: 32'd0, err: 1'b1};
        exp_lat = 1;
      end else begin
        p = '{we: 1'b0, addr: faddr, be: 4'hF, wdata: 32'd0, delay: fdelay, rdata: frdata};
        plan_q.push_back(p);
        if (fdelay >= TO) r = '{is_d: 1'b0, rdata: 32'd0, err: 1'b1};
        else              r = '{is_d: 1'b0, rdata: frdata, err: 1'b0};
        exp_lat = (fdelay >= TO) ? TO + 1 : fdelay + 2;
      end
      exp_q.push_back(r);
    end
    if (gap == 0) exp_lat = exp_lat + 1;
    if_req  = do_f;
    if_addr = faddr;
    d_read  = do_d && !wr ? 1'b1 : (do_d && ($urandom_range(0, 1) == 1));
    d_write = do_d && wr;
    d_size  = sz;
    d_usign = us;
    d_addr  = daddr;
    d_wdata = wdata;
    pend_f = do_f;
    pend_d = do_d;
    k = 0;
    while ((pend_f || pend_d) && k < 40) begin
      @(negedge clk);
      k++;
      if (pend_d && d_done) begin
        pend_d  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        if (!do_f) chk("data_latency", k, exp_lat);
      end else if (pend_f && if_done) begin
        pend_f = 1'b0;
        if_req = 1'b0;
        if (!do_d) chk("fetch_latency", k, exp_lat);
      end
    end
    if (pend_f || pend_d) begin
      chk("txn_done_timeout", {30'd0, pend_f, pend_d}, 32'd0);
      if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  // Bus slave: consumes one plan entry per bus cycle, checks the request, acks after the planned delay.
  initial begin : slave
    plan_t p;
    bit    active;
    int    wcnt;
    active = 1'b0;
    wcnt   = 0;
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (!rst_n || !slave_en) begin
        active = 1'b0;
      end else if (bus_req) begin
        if (!active) begin
          if (plan_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_bus_req: got bus_req=1 required 0 at %0t", $time);
            p = '{we: bus_we, addr: bus_addr, be: bus_be, wdata: bus_wdata, delay: 0, rdata: 32'd0};
          end else begin
            p = plan_q.pop_front();
          end
          active = 1'b1;
          wcnt   = 0;
        end
        chk("bus_we", {31'd0, bus_we}, {31'd0, p.we});
        chk("bus_addr", bus_addr, p.addr);
        chk("bus_be", {28'd0, bus_be}, {28'd0, p.be});
        if (p.we) chk("bus_wdata", bus_wdata, p.wdata);
        if (wcnt == p.delay) begin
          bus_ack   = 1'b1;
          bus_rdata = p.rdata;
        end
        wcnt++;
      end else if (active) begin
        chk("bus_req_cycles", wcnt, (p.delay < TO) ? p.delay + 1 : TO);
        active = 1'b0;
      end
    end
  end

  // Monitor: every done pulse pops and checks the oldest expected response.
  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && (if_done || d_done)) begin
        chk("single_done", {31'd0, if_done && d_done}, 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required 0 at %0t", $time);
        end else begin
          r = exp_q.pop_front();
          chk("done_port", {31'd0, d_done}, {31'd0, r.is_d});
          chk("resp_rdata", d_done ? d_rdata : if_rdata, r.rdata);
          chk("resp_err", {31'd0, d_done ? d_err : if_err}, {31'd0, r.err});
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    int          kind;
    bit          wr;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_size = '0; d_usign = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    rst_check("reset");
    rst_n = 1'b1;

    // Directed cases from the test plan
    run_txn(1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h100, 0, 0, 32'h0050_0093, 32'h0, 1);
    run_txn(0, 1, 0, 2'd0, 0, 32'h203, 32'h0, 32'h0, 0, 0, 32'h0, 32'h8000_0000, 1);
    run_txn(0, 1, 0, 2'd0, 1, 32'h203, 32'h0, 32'h0, 0, 0, 32'h0, 32'h8000_0000, 1);
    run_txn(0, 1, 1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    run_txn(1, 1, 1, 2'd2, 0, 32'h300, 32'hCAFE_F00D, 32'h104, 1, 0, 32'h1111_2222, 32'h0, 1);
    run_txn(0, 1, 0, 2'd2, 0, 32'h201, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    run_txn(0, 1, 0, 2'd2, 0, 32'h400, 32'h0, 32'h0, 0, 9, 32'h0, 32'h1234_5678, 1);
    run_txn(0, 1, 0, 2'd2, 0, 32'h404, 32'h0, 32'h0, 0, TO - 1, 32'h0, 32'h8765_4321, 1);
    run_txn(1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h102, 0, 0, 32'h0, 32'h0, 0);

    // Reset while a load is waiting on the bus
    @(negedge clk);
    slave_en = 1'b0;
    d_read = 1'b1; d_size = 2'd2; d_addr = 32'h500;
    repeat (2) @(negedge clk);
    chk("wait_bus_req", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 rst_check("async_reset");
    d_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    slave_en = 1'b1;
    run_txn(1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h200, 1, 0, 32'hDEAD_BEEF, 32'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 2);
      wr   = ($urandom_range(0, 1) == 1);
      a    = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      run_txn(kind != 1, kind != 0, wr, 2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
              $urandom, $urandom, a, $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom, $urandom, $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("plan_q_empty", plan_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
